// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop,
// LSB first, one bit per clock, with parallel result/carry/overflow.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             sum_bit,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cin_msb_q, cin_msb_d;

  logic s_bit;
  logic c_bit;

  assign s_bit = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign c_bit = (opa_q[0] & opb_q[0])
               | (opa_q[0] & carry_q)
               | (opb_q[0] & carry_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      cin_msb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      cin_msb_q <= cin_msb_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cin_msb_d = cin_msb_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
          opa_d     = a;
          opb_d     = sub ? ~b : b;
          carry_d   = sub;
          cnt_d     = '0;
          result_d  = '0;
          cin_msb_d = 1'b0;
          state_d   = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        result_d = {s_bit, result_q[WIDTH-1:1]};
        opa_d    = opa_q >> 1;
        opb_d    = opb_q >> 1;
        carry_d  = c_bit;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          cin_msb_d = carry_q;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flags are masked while running so they read as cleared after accept.
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum_bit   = s_bit;
  assign result    = result_q;
  assign carry_out = (state_q != RUN) & carry_q;
  assign overflow  = (state_q != RUN) & (cin_msb_q ^ carry_q);

endmodule
